// File: rtl/mem_arbiter.sv
// Shares one RAM port between the i- and d-requesters of CPUS cores.
// Data requests beat instruction requests; round-robin within a class.
module mem_arbiter #(
  parameter int CPUS   = 2,
  parameter int WORD_W = 32
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic [CPUS-1:0]          iREN,
  input  logic [CPUS*WORD_W-1:0]   iaddr,
  input  logic [CPUS-1:0]          dREN,
  input  logic [CPUS-1:0]          dWEN,
  input  logic [CPUS*WORD_W-1:0]   daddr,
  input  logic [CPUS*WORD_W-1:0]   dstore,
  output logic [CPUS-1:0]          iwait,
  output logic [CPUS-1:0]          dwait,
  output logic [CPUS*WORD_W-1:0]   iload,
  output logic [CPUS*WORD_W-1:0]   dload,
  output logic                     ramREN,
  output logic                     ramWEN,
  output logic [WORD_W-1:0]        ramaddr,
  output logic [WORD_W-1:0]        ramstore,
  input  logic [WORD_W-1:0]        ramload,
  input  logic [1:0]               ramstate
);

  localparam int CW = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  typedef enum logic {IDLE, SERVE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]     gnt_core_q, gnt_core_d;
  logic              gnt_is_d_q, gnt_is_d_d;
  logic              ram_ren_q, ram_ren_d;
  logic              ram_wen_q, ram_wen_d;
  logic [WORD_W-1:0] ram_addr_q, ram_addr_d;
  logic [WORD_W-1:0] ram_store_q, ram_store_d;

  logic [WORD_W-1:0] iaddr_a  [CPUS];
  logic [WORD_W-1:0] daddr_a  [CPUS];
  logic [WORD_W-1:0] dstore_a [CPUS];
  logic [CPUS-1:0]   d_req;
  logic [CW:0]       i_pick, d_pick;
  logic              gnt_req, done;

  for (genvar k = 0; k < CPUS; k++) begin : g_unpack
    assign iaddr_a[k]  = iaddr[k*WORD_W +: WORD_W];
    assign daddr_a[k]  = daddr[k*WORD_W +: WORD_W];
    assign dstore_a[k] = dstore[k*WORD_W +: WORD_W];
  end

  assign d_req = dREN | dWEN;

  // Returns {found, index} of the first requester at or above ptr, wrapping.
  function automatic logic [CW:0] rr_pick(input logic [CPUS-1:0] req,
                                          input logic [CW-1:0] ptr);
    logic [CW:0] cand;
    logic [CW:0] res;
    logic        found;
    res   = '0;
    found = 1'b0;
    for (int i = 0; i < CPUS; i++) begin
      cand = {1'b0, ptr} + (CW+1)'(i);
      if (cand >= (CW+1)'(CPUS)) cand = cand - (CW+1)'(CPUS);
      if (!found && req[cand[CW-1:0]]) begin
        found = 1'b1;
        res   = {1'b1, cand[CW-1:0]};
      end
    end
    return res;
  endfunction

  assign i_pick  = rr_pick(iREN, rr_ptr_q);
  assign d_pick  = rr_pick(d_req, rr_ptr_q);
  assign gnt_req = gnt_is_d_q ? d_req[gnt_core_q] : iREN[gnt_core_q];
  assign done    = (state_q == SERVE) && gnt_req && (ramstate == RAM_ACCESS);

  always_comb begin
    iwait = iREN;
    dwait = d_req;
    if (done) begin
      if (gnt_is_d_q) dwait[gnt_core_q] = 1'b0;
      else            iwait[gnt_core_q] = 1'b0;
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_core_d  = gnt_core_q;
    gnt_is_d_d  = gnt_is_d_q;
    ram_ren_d   = ram_ren_q;
    ram_wen_d   = ram_wen_q;
    ram_addr_d  = ram_addr_q;
    ram_store_d = ram_store_q;
    case (state_q)
      IDLE: begin
        if (d_pick[CW] || i_pick[CW]) begin
          state_d    = SERVE;
          gnt_is_d_d = d_pick[CW];
          gnt_core_d = d_pick[CW] ? d_pick[CW-1:0] : i_pick[CW-1:0];
          // A simultaneous read and write from the same dcache is treated as a write.
          ram_wen_d   = d_pick[CW] && dWEN[gnt_core_d];
          ram_ren_d   = !ram_wen_d;
          ram_addr_d  = d_pick[CW] ? daddr_a[gnt_core_d] : iaddr_a[gnt_core_d];
          ram_store_d = d_pick[CW] ? dstore_a[gnt_core_d] : '0;
        end
      end
      SERVE: begin
        if (!gnt_req || ramstate == RAM_ACCESS || ramstate == RAM_ERROR) begin
          state_d   = IDLE;
          ram_ren_d = 1'b0;
          ram_wen_d = 1'b0;
          if (done)
            rr_ptr_d = (gnt_core_q == CW'(CPUS-1)) ? '0 : gnt_core_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      gnt_core_q  <= '0;
      gnt_is_d_q  <= 1'b0;
      ram_ren_q   <= 1'b0;
      ram_wen_q   <= 1'b0;
      ram_addr_q  <= '0;
      ram_store_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      gnt_core_q  <= gnt_core_d;
      gnt_is_d_q  <= gnt_is_d_d;
      ram_ren_q   <= ram_ren_d;
      ram_wen_q   <= ram_wen_d;
      ram_addr_q  <= ram_addr_d;
      ram_store_q <= ram_store_d;
    end
  end

  assign ramREN   = ram_ren_q;
  assign ramWEN   = ram_wen_q;
  assign ramaddr  = ram_addr_q;
  assign ramstore = ram_store_q;
  assign iload    = {CPUS{ramload}};
  assign dload    = {CPUS{ramload}};

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one unified RAM port between the instruction and data caches of CPUS cores.
- Each cache presents a blocking word request. The arbiter picks one request, holds it on the RAM port until the RAM acknowledges, then releases that requester's wait for one cycle.
- Sits between the per-core cache control signals and the RAM model or controller at the top of the memory system.

Parameters:
- CPUS, 2, number of cores; each core has one i-requester and one d-requester.
- WORD_W, 32, width of addresses and data words.

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- iREN  in  CPUS  instruction read request, per core.
- iaddr  in  CPUS*WORD_W  instruction address; core k occupies bits [k*WORD_W +: WORD_W].
- dREN  in  CPUS  data read request, per core.
- dWEN  in  CPUS  data write request, per core.
- daddr  in  CPUS*WORD_W  data address, per core.
- dstore  in  CPUS*WORD_W  data write value, per core.
- iwait  out  CPUS  high while core k's i-request is not completing this cycle.
- dwait  out  CPUS  high while core k's d-request is not completing this cycle.
- iload  out  CPUS*WORD_W  read data returned to each core's icache.
- dload  out  CPUS*WORD_W  read data returned to each core's dcache.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  WORD_W  RAM address.
- ramstore  out  WORD_W  RAM write data.
- ramload  in  WORD_W  RAM read data.
- ramstate  in  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR.

Behaviour:
- Reset (async, nRST=0):
  - FSM goes to IDLE; rr_ptr=0; granted source cleared.
  - ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
  - Because no grant exists, every iwait/dwait bit equals its request bit.
  - Reset asserted mid-transaction aborts that transaction immediately; no completion is signalled.
- FSM has two states: IDLE and SERVE.
- IDLE:
  - If any request is present, the winner is registered and the FSM moves to SERVE on the next edge.
  - RAM enables stay 0 while in IDLE.
- Arbitration priority:
  - Every data request (dREN|dWEN) beats every instruction request.
  - Within a class, the winner is the first requesting core scanning from rr_ptr upward, wrapping CPUS-1 to 0.
- SERVE:
  - RAM outputs are driven from registers holding the latched source: core index, class, address, store data and WEN.
  - For an i-grant: ramREN=1, ramWEN=0.
  - For a d-grant with dWEN=1: ramWEN=1, ramREN=0. If dREN and dWEN are both high, the write wins.
  - For a d-grant with only dREN=1: ramREN=1, ramWEN=0.
  - Address and data are sampled once at grant; changes on the inputs during SERVE are ignored.
- Completion:
  - In the cycle ramstate==ACCESS while in SERVE, the granted requester's wait bit goes low (combinational).
  - In that cycle its load bus carries ramload.
  - Next edge: FSM returns to IDLE and rr_ptr = (granted core + 1) mod CPUS.
- ERROR:
  - On ramstate==ERROR in SERVE, the FSM returns to IDLE with no completion and rr_ptr unchanged, so the same request re-arbitrates (retry).
- Request withdrawn during SERVE (the granted request bit drops):
  - Abort: next edge returns to IDLE, RAM enables 0, rr_ptr unchanged.
- Load buses:
  - iload and dload present ramload on every core slice at all times.
  - The data is valid only while the corresponding wait is low.
- Latency:
  - Request seen in IDLE at cycle 0; RAM enabled in cycle 1; completion in the first cycle with ACCESS.
  - Minimum 2 cycles per transaction with a zero-wait RAM; 1 idle cycle between back-to-back transactions.
- Ungranted requests keep their wait high. Only one transaction is outstanding at any time.

Test Plan:
- Reset, then only iREN[0]=1 with iaddr0=0x0000_0040; RAM returns ACCESS one cycle after ramREN=1 with ramload=0xDEAD_BEEF -> ramaddr=0x40, ramREN=1, then iwait[0]=0 for exactly one cycle with iload slice0=0xDEAD_BEEF.
- iREN[0]=1 and dWEN[1]=1 (daddr1=0x100, dstore1=0x1234) in the same cycle -> d1 is served first: ramWEN=1, ramaddr=0x100, ramstore=0x1234. i0 is served afterwards; iwait[0] stays high throughout the d1 transaction.
- dREN[0]=dREN[1]=1 held continuously, 4 transactions -> grants alternate in the order core0, core1, core0, core1.
- ramstate=ERROR on the first attempt for dREN[0] -> no dwait[0] pulse, re-grant to core0 with the same address, completes on a following ACCESS.
- nRST pulsed low during SERVE -> ramREN/ramWEN go 0 immediately and asynchronously; after release, the still-pending request is re-granted starting from rr_ptr=0.
- dREN[1]=1 granted, then dropped before ACCESS -> abort with no dwait pulse; FSM back in IDLE; rr_ptr unchanged.
